pipe_skid_buffer: RTL and testbench

// - Elastic valid/ready stage (2-entry skid buffer) between a streaming producer and a register/datapath stage.
// - Sustains 1 transfer/cycle and breaks the combinational ready path: in_ready is a flop, never a function of out_ready.
// - Preserves order; never drops or duplicates a word. Used to pipeline long valid/ready paths between registered stages.

---
 rtl/pipe_skid_buffer.sv | 86 ++++++++
 tb/tb_pipe_skid_buffer.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/pipe_skid_buffer.sv
// pipe_skid_buffer: two-entry elastic valid/ready stage. in_ready comes from a
// flop and never depends on out_ready, which breaks the combinational ready
// path. A word that arrives while the consumer stalls is held in the skid
// register and moves into main when the consumer drains.
module pipe_skid_buffer #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       count
);

  // The state encoding is the occupancy, so count is read directly from it
  localparam logic [1:0] EMPTY = 2'd0;
  localparam logic [1:0] BUSY  = 2'd1;
  localparam logic [1:0] FULL  = 2'd2;

  logic [1:0]       state, state_next;
  logic [WIDTH-1:0] main_q, main_next;
  logic [WIDTH-1:0] skid_q, skid_next;
  logic             ready_q;
  logic             in_fire, out_fire;

  assign in_ready  = ready_q;
  assign out_valid = (state != EMPTY);
  assign out_data  = main_q;
  assign count     = state;

  assign in_fire  = in_valid & ready_q;
  assign out_fire = out_valid & out_ready;

  // Next-state and datapath selection; registers not selected keep their value
  always_comb begin
    state_next = state;
    main_next  = main_q;
    skid_next  = skid_q;
    case (state)
      EMPTY: begin
        if (in_fire) begin
          state_next = BUSY;
          main_next  = in_data;
        end
      end
      BUSY: begin
        if (in_fire && out_fire) begin
          main_next = in_data;
        end else if (in_fire) begin
          state_next = FULL;
          skid_next  = in_data;
        end else if (out_fire) begin
          state_next = EMPTY;
        end
      end
      FULL: begin
        if (out_fire) begin
          state_next = BUSY;
          main_next  = skid_q;
        end
      end
      default: state_next = EMPTY;
    endcase
  end

  // State and data registers; reset discards all contents immediately
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= EMPTY;
      main_q  <= '0;
      skid_q  <= '0;
      ready_q <= 1'b0;
    end else begin
      state   <= state_next;
      main_q  <= main_next;
      skid_q  <= skid_next;
      // in_ready is low only while both entries are occupied
      ready_q <= (state_next != FULL);
    end
  end

endmodule

// File: tb/tb_pipe_skid_buffer.sv
// tb_pipe_skid_buffer: directed checks of reset, passthrough, backpressure,
// drain/refill and mid-operation reset, followed by a randomized run against
// a queue model of the buffer.
module tb_pipe_skid_buffer;

  localparam int unsigned WIDTH = 8;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [WIDTH-1:0] in_data = '0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [WIDTH-1:0] out_data;
  logic [1:0]       count;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  pipe_skid_buffer #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .count     (count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Advance one clock; inputs are driven and outputs sampled 1 ns after the edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_stall(input logic [WIDTH-1:0] d);
    in_valid = 1'b1;
    in_data  = d;
    step();
  endtask

  logic [WIDTH-1:0] q[$];
  logic             iv, ordy;
  logic [WIDTH-1:0] id;
  logic             prev_stall;
  logic [WIDTH-1:0] prev_data;
  int unsigned      n_out;
  int unsigned      cycles;

  initial begin
    // Reset held with in_valid asserted
    in_valid = 1'b1;
    in_data  = 8'hEE;
    repeat (5) step();
    check("rst_out_valid", out_valid, 0);
    check("rst_in_ready", in_ready, 0);
    check("rst_count", count, 0);
    rst = 1'b1;
    step();
    check("rel_in_ready", in_ready, 1);
    check("rel_count", count, 0);
    in_valid = 1'b0;

    // Passthrough, back-to-back with zero-wait consumer
    out_ready = 1'b1;
    for (int i = 0; i < 100; i++) begin
      in_valid = 1'b1;
      in_data  = i[WIDTH-1:0];
      step();
      check("pass_in_ready", in_ready, 1);
      check("pass_out_valid", out_valid, 1);
      check("pass_data", out_data, i);
      check("pass_count", count, 1);
    end
    in_valid = 1'b0;
    step();
    check("pass_drained", out_valid, 0);

    // Backpressure: two words held, then drained in order
    out_ready = 1'b0;
    push_stall(8'hA5);
    check("bp_count1", count, 1);
    push_stall(8'h3C);
    in_valid = 1'b0;
    check("bp_count2", count, 2);
    check("bp_in_ready", in_ready, 0);
    for (int i = 0; i < 10; i++) begin
      step();
      check("bp_hold_data", out_data, 8'hA5);
      check("bp_hold_valid", out_valid, 1);
      check("bp_hold_count", count, 2);
    end
    out_ready = 1'b1;
    check("bp_first", out_data, 8'hA5);
    step();
    check("bp_second", out_data, 8'h3C);
    check("bp_ready_back", in_ready, 1);
    check("bp_count_1", count, 1);
    step();
    check("bp_empty_valid", out_valid, 0);
    check("bp_empty_count", count, 0);

    // Drain/refill from FULL: one-cycle out_ready pulse with input pending
    out_ready = 1'b0;
    push_stall(8'h11);
    push_stall(8'h22);
    in_data   = 8'h33;
    out_ready = 1'b1;
    step();
    check("dr_one_out", out_data, 8'h22);
    check("dr_count", count, 1);
    check("dr_ready", in_ready, 1);
    out_ready = 1'b0;
    step();
    check("dr_refill_count", count, 2);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    check("dr_head", out_data, 8'h22);
    step();
    check("dr_new_word", out_data, 8'h33);
    step();
    check("dr_empty", out_valid, 0);

    // Reset asserted between edges while FULL
    out_ready = 1'b0;
    push_stall(8'h44);
    push_stall(8'h55);
    in_valid = 1'b0;
    check("mr_full", count, 2);
    #2 rst = 1'b0;
    #1;
    check("mr_out_valid", out_valid, 0);
    check("mr_count", count, 0);
    check("mr_in_ready", in_ready, 0);
    check("mr_data", out_data, 0);
    step();
    rst = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      check("mr_no_stale", out_valid, 0);
    end

    // Randomized traffic against a queue model
    q.delete();
    prev_stall = 1'b0;
    prev_data  = '0;
    n_out  = 0;
    cycles = 0;
    while (n_out < 10000 && cycles < 60000) begin
      check("rnd_count", count, q.size());
      check("rnd_in_ready", in_ready, (q.size() != 2));
      check("rnd_out_valid", out_valid, (q.size() != 0));
      if (q.size() != 0) check("rnd_data", out_data, q[0]);
      if (prev_stall) check("rnd_stable", out_data, prev_data);
      iv   = ($urandom_range(0, 3) != 0);
      ordy = ($urandom_range(0, 2) != 0);
      id   = WIDTH'($urandom);
      in_valid  = iv;
      in_data   = id;
      out_ready = ordy;
      prev_stall = (q.size() != 0) && !ordy;
      prev_data  = (q.size() != 0) ? q[0] : '0;
      if ((q.size() != 0) && ordy) begin
        void'(q.pop_front());
        n_out++;
      end
      // The model only accepts when it had room before this edge
      if (iv && (q.size() + ((prev_stall || (q.size() == 0)) ? 0 : 1) < 2)) q.push_back(id);
      step();
      cycles++;
    end
    check("rnd_transfers", n_out, 10000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
